rst_sequencer: RTL
==================

Name: rst_sequencer

Overview:
- Reset front-end placed between the raw board inputs (reset button, UART DTR) and the CPU core's `i_rst`.
- Synchronizes both inputs and qualifies DTR with a minimum-assertion filter.
- Turns each reset source into a clean, stretched, registered reset pulse.
- Reports the last reset cause and a count of external resets, which the top level can route into GPIO input bits for firmware or bootloader inspection.

Parameters:
- POR_CYCLES, 16: cycles `o_rst` is held after `i_rst` deasserts. Must be ≥1.
- STRETCH_CYCLES, 1024: cycles `o_rst` is held after a button press or DTR release. Must be ≥1.
- DTR_MIN_CYCLES, 5000000: consecutive synchronized DTR-active cycles needed to qualify (0.2 s at 25 MHz). Must be ≥1.

Ports:
- `i_clk` input 1: system clock.
- `i_rst` input 1: synchronous, active-high reset (power-on / FPGA init).
- `i_btn_n` input 1: raw reset button, active-low, asynchronous.
- `i_dtr_n` input 1: raw UART DTR, active-low, asynchronous.
- `o_rst` output 1: registered reset to the CPU, active-high.
- `o_rst_cause` output 2: last reset cause. 00 = POR, 01 = button, 10 = DTR, 11 unused.
- `o_rst_count` output 8: saturating count of button+DTR resets since `i_rst`.

Behaviour:
- Synchronization:
  - Two-flop synchronizers on `~i_btn_n` → `btn_s` and `~i_dtr_n` → `dtr_s`.
  - Synchronizer flops reset to 0 (inactive) on `i_rst`.
- Button press:
  - `btn_prev` is a register of `btn_s`.
  - `press = btn_s & ~btn_prev`, a single-cycle strobe.
  - A held button yields one press only.
- DTR qualifier:
  - Counter `dcnt` with width `$clog2(DTR_MIN_CYCLES+1)`.
  - Clears to 0 whenever `dtr_s` = 0.
  - Increments each cycle `dtr_s` = 1, saturating at DTR_MIN_CYCLES.
  - `dtr_q = (dcnt == DTR_MIN_CYCLES)` (combinational).
  - The qualifier runs in every state.
- State machine:
  - States: S_POR, S_RUN, S_HOLD, S_STRETCH.
  - One shared down-counter `cnt`, sized for max(POR_CYCLES, STRETCH_CYCLES).
  - `o_rst` is a flop updated with the state: it is 1 exactly when the next state is not S_RUN.
- On `i_rst` (any state, mid-sequence included):
  - state = S_POR, cnt = POR_CYCLES-1.
  - `o_rst` = 1, `o_rst_cause` = 00, `o_rst_count` = 0.
  - `dcnt` = 0, `btn_prev` = 0.
- S_POR:
  - If cnt ≠ 0: cnt decrements and presses are ignored.
  - If cnt == 0 and `dtr_q`: go to S_HOLD, cause = 10, count += 1.
  - If cnt == 0 and not `dtr_q`: go to S_RUN.
- S_RUN:
  - If `dtr_q`: go to S_HOLD, cause = 10, count += 1.
  - Otherwise, if `press`: go to S_STRETCH, cnt = STRETCH_CYCLES-1, cause = 01, count += 1.
  - DTR has priority when both occur in the same cycle.
- S_HOLD:
  - Stay while `dtr_s` = 1. Presses are ignored.
  - When `dtr_s` = 0: go to S_STRETCH, cnt = STRETCH_CYCLES-1.
- S_STRETCH:
  - If `dtr_q`: go to S_HOLD, cause = 10, count += 1.
  - Otherwise, if `press`: restart with cnt = STRETCH_CYCLES-1, cause = 01, count += 1.
  - Otherwise, if cnt == 0: go to S_RUN.
  - Otherwise: cnt decrements.
- Timing:
  - After `i_rst` falls, `o_rst` stays 1 for exactly POR_CYCLES cycles.
  - A button-only reset holds `o_rst` = 1 for exactly STRETCH_CYCLES cycles.
  - Button latency: a raw press meeting setup before edge E gives `o_rst` = 1 after edge E+2.
  - DTR latency: sustained DTR meeting setup before edge E gives `o_rst` = 1 after edge E+DTR_MIN_CYCLES+2.
  - A DTR pulse shorter than DTR_MIN_CYCLES synchronized cycles never resets.
- `o_rst_count` saturates at 255 (no wrap).
- `o_rst_cause` holds its value until the next event and stays valid while in S_RUN.

Test Plan (all with POR_CYCLES = 4, STRETCH_CYCLES = 8, DTR_MIN_CYCLES = 8):
- Power-on: assert `i_rst` for 3 cycles, then release → `o_rst` = 1 for exactly 4 cycles after release, then 0; cause = 00, count = 0.
- Button: after POR, drive `i_btn_n` low for 20 cycles → `o_rst` rises 3 edges later, stays high 8 cycles, then 0; one event only; cause = 01, count = 1.
- Button retrigger: second press (release then re-press) during the stretch → stretch restarts; `o_rst` stays high 8 cycles after the second press registers; count = 2.
- DTR short: drive `i_dtr_n` low for 7 cycles → `o_rst` never asserts; count unchanged. Then hold low for 30 cycles → `o_rst` rises at edge 10 after assertion, stays high while DTR is low, and stays high 8 more cycles after `dtr_s` falls; cause = 10.
- Simultaneous: DTR qualifies in the same cycle as a button press in S_RUN → S_HOLD entered, cause = 10, count increments by 1 only.
- Reset mid-stretch plus saturation:
  - Assert `i_rst` during S_STRETCH → POR sequence restarts and count = 0.
  - Then apply 300 button presses → count saturates at 255.

Source files
------------

// File: rtl/rst_sequencer.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | Module : rst_sequencer                                                  |
// | Brief  : Synchronizes button/DTR reset requests and produces a          |
// |          stretched CPU reset with cause and event-count reporting.      |
// | Rev    : 1.0 - initial release                                          |
// +-------------------------------------------------------------------------+
module rst_sequencer #(
  parameter int unsigned POR_CYCLES     = 16,
  parameter int unsigned STRETCH_CYCLES = 1024,
  parameter int unsigned DTR_MIN_CYCLES = 5000000
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_btn_n,
  input  logic       i_dtr_n,
  output logic       o_rst,
  output logic [1:0] o_rst_cause,
  output logic [7:0] o_rst_count
);

  localparam int unsigned CNT_MAX = (POR_CYCLES > STRETCH_CYCLES) ? POR_CYCLES : STRETCH_CYCLES;
  localparam int CNT_W  = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int DCNT_W = $clog2(DTR_MIN_CYCLES + 1);

  localparam logic [CNT_W-1:0]  C_POR_LOAD = CNT_W'(POR_CYCLES - 1);
  localparam logic [CNT_W-1:0]  C_STR_LOAD = CNT_W'(STRETCH_CYCLES - 1);
  localparam logic [DCNT_W-1:0] C_DTR_MIN  = DCNT_W'(DTR_MIN_CYCLES);

  localparam logic [1:0] C_CAUSE_POR = 2'b00;
  localparam logic [1:0] C_CAUSE_BTN = 2'b01;
  localparam logic [1:0] C_CAUSE_DTR = 2'b10;

  typedef enum logic [1:0] {
    S_POR     = 2'd0,
    S_RUN     = 2'd1,
    S_HOLD    = 2'd2,
    S_STRETCH = 2'd3
  } state_e;

  logic              btn_meta_q, btn_s_q, btn_prev_q;
  logic              dtr_meta_q, dtr_s_q;
  logic [DCNT_W-1:0] dcnt_q;
  logic              press;
  logic              dtr_qual;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [1:0]        cause_q, cause_d;
  logic [7:0]        count_q, count_d;
  logic [7:0]        count_inc;
  logic              rst_q, rst_d;

  // Input synchronizers, press edge detect and DTR qualification counter.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      btn_meta_q <= 1'b0;
      btn_s_q    <= 1'b0;
      btn_prev_q <= 1'b0;
      dtr_meta_q <= 1'b0;
      dtr_s_q    <= 1'b0;
      dcnt_q     <= '0;
    end else begin
      btn_meta_q <= ~i_btn_n;
      btn_s_q    <= btn_meta_q;
      btn_prev_q <= btn_s_q;
      dtr_meta_q <= ~i_dtr_n;
      dtr_s_q    <= dtr_meta_q;
      if (!dtr_s_q) begin
        dcnt_q <= '0;
      end else if (dcnt_q != C_DTR_MIN) begin
        dcnt_q <= dcnt_q + DCNT_W'(1);
      end
    end
  end

  assign press     = btn_s_q & ~btn_prev_q;
  assign dtr_qual  = (dcnt_q == C_DTR_MIN);
  assign count_inc = (count_q == 8'hFF) ? count_q : count_q + 8'd1;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cause_d = cause_q;
    count_d = count_q;
    case (state_q)
      S_POR: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else if (dtr_qual) begin
          state_d = S_HOLD;
          cause_d = C_CAUSE_DTR;
          count_d = count_inc;
        end else begin
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        // DTR wins over a coincident button press.
        if (dtr_qual) begin
          state_d = S_HOLD;
          cause_d = C_CAUSE_DTR;
          count_d = count_inc;
        end else if (press) begin
          state_d = S_STRETCH;
          cnt_d   = C_STR_LOAD;
          cause_d = C_CAUSE_BTN;
          count_d = count_inc;
        end
      end
      S_HOLD: begin
        if (!dtr_s_q) begin
          state_d = S_STRETCH;
          cnt_d   = C_STR_LOAD;
        end
      end
      S_STRETCH: begin
        if (dtr_qual) begin
          state_d = S_HOLD;
          cause_d = C_CAUSE_DTR;
          count_d = count_inc;
        end else if (press) begin
          cnt_d   = C_STR_LOAD;
          cause_d = C_CAUSE_BTN;
          count_d = count_inc;
        end else if (cnt_q == '0) begin
          state_d = S_RUN;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = S_POR;
        cnt_d   = C_POR_LOAD;
      end
    endcase
    rst_d = (state_d != S_RUN);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= S_POR;
      cnt_q   <= C_POR_LOAD;
      cause_q <= C_CAUSE_POR;
      count_q <= 8'd0;
      rst_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cause_q <= cause_d;
      count_q <= count_d;
      rst_q   <= rst_d;
    end
  end

  assign o_rst       = rst_q;
  assign o_rst_cause = cause_q;
  assign o_rst_count = count_q;

endmodule
`default_nettype wire
